// File: rtl/array_2d_bist_pkg.sv
// rtl/array_2d_bist_pkg.sv - shared types, constants and pattern function for the 2D array BIST
//
// Contents:
//   state_t    - controller phases (IDLE, CLEAR, FILL, CHECK, DRAIN, DONE)
//   FILL_VALUE - background word written during CLEAR (all ones, slice to WB)
//   pat()      - coordinate pattern {a[WB/2-1:0], c[WB/2-1:0]}, zero-extended

package array_2d_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FILL,
        CHECK,
        DRAIN,
        DONE
    } state_t;

    // Widest word supported; callers slice the low WB bits.
    localparam int MAX_WB = 64;

    localparam logic [MAX_WB-1:0] FILL_VALUE = {MAX_WB{1'b1}};

    // Upper half of the word carries the row, lower half the column.
    function automatic logic [MAX_WB-1:0] pat(input logic [31:0] a,
                                              input logic [31:0] c,
                                              input int          wb);
        logic [MAX_WB-1:0] mask;
        int                h;
        h    = wb / 2;
        mask = (64'd1 << h) - 64'd1;
        return (({32'd0, a} & mask) << h) | ({32'd0, c} & mask);
    endfunction

endpackage

// File: rtl/array_2d_bist_if.sv
// rtl/array_2d_bist_if.sv - control, status and memory-port bundle of the 2D array BIST
//
// Signals:
//   start, wa, wc                   - run request and fill-region extents
//   mem_we, mem_re, mem_a, mem_c,
//   mem_wdata, mem_rdata            - single array port (rdata valid 1 cycle after mem_re)
//   busy, done, pass, err_cnt,
//   fail_a, fail_c                  - run status and first-failure coordinates
// Modports:
//   master - the BIST controller
//   slave  - the surrounding datapath / requester

interface array_2d_bist_if #(
    parameter int WA  = 4,
    parameter int WC  = 4,
    parameter int WB  = 8,
    parameter int ECW = 16
);
    localparam int AW  = (WA > 1) ? $clog2(WA) : 1;
    localparam int CW  = (WC > 1) ? $clog2(WC) : 1;
    localparam int LAW = $clog2(WA + 1);
    localparam int LCW = $clog2(WC + 1);

    logic           start;
    logic [LAW-1:0] wa;
    logic [LCW-1:0] wc;
    logic           mem_we;
    logic           mem_re;
    logic [AW-1:0]  mem_a;
    logic [CW-1:0]  mem_c;
    logic [WB-1:0]  mem_wdata;
    logic [WB-1:0]  mem_rdata;
    logic           busy;
    logic           done;
    logic           pass;
    logic [ECW-1:0] err_cnt;
    logic [AW-1:0]  fail_a;
    logic [CW-1:0]  fail_c;

    modport master (
        input  start, wa, wc, mem_rdata,
        output mem_we, mem_re, mem_a, mem_c, mem_wdata,
               busy, done, pass, err_cnt, fail_a, fail_c
    );

    modport slave (
        output start, wa, wc, mem_rdata,
        input  mem_we, mem_re, mem_a, mem_c, mem_wdata,
               busy, done, pass, err_cnt, fail_a, fail_c
    );

endinterface

// File: rtl/array_2d_scan.sv
// rtl/array_2d_scan.sv - row-major 2D address counter shared by all BIST phases
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   clear         - force the position back to (0,0)
//   enable        - advance one word (column fastest)
//   lim_a, lim_c  - row/column counts of the region being walked
//   a, c          - current position
//   last          - current position is the final word of the region

module array_2d_scan #(
    parameter int AW  = 2,
    parameter int CW  = 2,
    parameter int LAW = 3,
    parameter int LCW = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           enable,
    input  logic [LAW-1:0] lim_a,
    input  logic [LCW-1:0] lim_c,
    output logic [AW-1:0]  a,
    output logic [CW-1:0]  c,
    output logic           last
);
    logic last_a;
    logic last_c;

    assign last_a = (LAW'(a) + LAW'(1)) == lim_a;
    assign last_c = (LCW'(c) + LCW'(1)) == lim_c;
    assign last   = last_a && last_c;

    // Wrapping on the final word returns to (0,0), so the next phase starts
    // from the origin without an extra clear cycle.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            a <= '0;
            c <= '0;
        end else if (enable) begin
            if (last_c) begin
                c <= '0;
                a <= last_a ? '0 : a + AW'(1);
            end else begin
                c <= c + CW'(1);
            end
        end
    end

endmodule

// File: rtl/array_2d_bist.sv
// rtl/array_2d_bist.sv - clear / fill / check BIST controller for a WA x WC array of WB-bit words
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - array_2d_bist_if.master: start/wa/wc in, memory port out, rdata in,
//          busy/done/pass/err_cnt/fail_a/fail_c status out
//
// The state register names the phase of the word issued at the next edge;
// the memory port and status outputs are all registered.

module array_2d_bist
    import array_2d_bist_pkg::*;
#(
    parameter int WA  = 4,
    parameter int WC  = 4,
    parameter int WB  = 8,
    parameter int ECW = 16
) (
    input  logic            clk,
    input  logic            rst,
    array_2d_bist_if.master bus
);
    localparam int AW  = (WA > 1) ? $clog2(WA) : 1;
    localparam int CW  = (WC > 1) ? $clog2(WC) : 1;
    localparam int LAW = $clog2(WA + 1);
    localparam int LCW = $clog2(WC + 1);

    localparam logic [LAW-1:0] WA_N   = LAW'(WA);
    localparam logic [LCW-1:0] WC_N   = LCW'(WC);
    localparam logic [WB-1:0]  FILL_W = FILL_VALUE[WB-1:0];

    state_t         state;
    logic           busy_q, done_q, pass_q, first_seen;
    logic           mem_we_q, mem_re_q;
    logic [AW-1:0]  mem_a_q, cmp_a, fail_a_q;
    logic [CW-1:0]  mem_c_q, cmp_c, fail_c_q;
    logic [WB-1:0]  mem_wdata_q, exp_q, cmp_exp;
    logic           cmp_v;
    logic [ECW-1:0] err_q;
    logic [LAW-1:0] wa_l;
    logic [LCW-1:0] wc_l;

    logic           start_ok, issuing, in_region, mis;
    state_t         iss, nxt;
    logic [LAW-1:0] wa_in_l, wa_n, lim_a;
    logic [LCW-1:0] wc_in_l, wc_n, lim_c;
    logic [AW-1:0]  scan_a;
    logic [CW-1:0]  scan_c;
    logic           scan_last;
    logic [WB-1:0]  pat_w, wdata_n, exp_n;
    logic [ECW-1:0] err_next;

    assign wa_in_l = (bus.wa > WA_N) ? WA_N : bus.wa;
    assign wc_in_l = (bus.wc > WC_N) ? WC_N : bus.wc;

    always_comb begin
        // busy is still high during the done cycle, so a start there is ignored.
        start_ok = (state == IDLE) && !busy_q && bus.start;
        // The start edge itself issues the first CLEAR word.
        iss      = start_ok ? CLEAR : state;
        issuing  = (iss == CLEAR) || (iss == FILL) || (iss == CHECK);

        // Extents are not latched yet on the start edge; use the live inputs there.
        wa_n = (state == IDLE) ? wa_in_l : wa_l;
        wc_n = (state == IDLE) ? wc_in_l : wc_l;

        if (iss == FILL) begin
            lim_a = wa_n;
            lim_c = wc_n;
        end else begin
            lim_a = WA_N;
            lim_c = WC_N;
        end

        case (iss)
            CLEAR:   nxt = (wa_n == '0 || wc_n == '0) ? CHECK : FILL;
            FILL:    nxt = CHECK;
            CHECK:   nxt = DRAIN;
            default: nxt = iss;
        endcase

        pat_w     = WB'(pat(32'(scan_a), 32'(scan_c), WB));
        in_region = (LAW'(scan_a) < wa_n) && (LCW'(scan_c) < wc_n);
        exp_n     = in_region ? pat_w : FILL_W;
        wdata_n   = (iss == FILL) ? pat_w : FILL_W;

        mis      = cmp_v && (bus.mem_rdata != cmp_exp);
        err_next = (mis && !(&err_q)) ? err_q + ECW'(1) : err_q;
    end

    array_2d_scan #(
        .AW (AW),
        .CW (CW),
        .LAW(LAW),
        .LCW(LCW)
    ) u_scan (
        .clk   (clk),
        .rst   (rst),
        .clear ((state == IDLE) && !start_ok),
        .enable(issuing),
        .lim_a (lim_a),
        .lim_c (lim_c),
        .a     (scan_a),
        .c     (scan_c),
        .last  (scan_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            first_seen  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_a_q     <= '0;
            mem_c_q     <= '0;
            mem_wdata_q <= '0;
            exp_q       <= '0;
            cmp_v       <= 1'b0;
            cmp_exp     <= '0;
            cmp_a       <= '0;
            cmp_c       <= '0;
            err_q       <= '0;
            fail_a_q    <= '0;
            fail_c_q    <= '0;
            wa_l        <= '0;
            wc_l        <= '0;
        end else begin
            mem_we_q <= issuing && (iss != CHECK);
            mem_re_q <= issuing && (iss == CHECK);
            if (issuing) begin
                mem_a_q     <= scan_a;
                mem_c_q     <= scan_c;
                mem_wdata_q <= wdata_n;
                exp_q       <= exp_n;
                state       <= scan_last ? nxt : iss;
            end

            // Read data returns one cycle after the strobe; compare against
            // the coordinates/expected word that travelled with it.
            cmp_v   <= mem_re_q;
            cmp_exp <= exp_q;
            cmp_a   <= mem_a_q;
            cmp_c   <= mem_c_q;

            err_q <= err_next;
            if (mis && !first_seen) begin
                first_seen <= 1'b1;
                fail_a_q   <= cmp_a;
                fail_c_q   <= cmp_c;
            end

            done_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        busy_q     <= 1'b1;
                        wa_l       <= wa_in_l;
                        wc_l       <= wc_in_l;
                        err_q      <= '0;
                        fail_a_q   <= '0;
                        fail_c_q   <= '0;
                        first_seen <= 1'b0;
                        pass_q     <= 1'b0;
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                DRAIN: state <= DONE;
                DONE: begin
                    done_q <= 1'b1;
                    pass_q <= (err_next == '0);
                    state  <= IDLE;
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_a     = mem_a_q;
    assign bus.mem_c     = mem_c_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_cnt   = err_q;
    assign bus.fail_a    = fail_a_q;
    assign bus.fail_c    = fail_c_q;

endmodule

// File: tb/tb_array_2d_bist.sv
// tb/tb_array_2d_bist.sv - self-checking bench for array_2d_bist (WA=4, WC=3, WB=8)

module tb_array_2d_bist;
    localparam int WA = 4;
    localparam int WC = 3;
    localparam int WB = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    array_2d_bist_if #(.WA(WA), .WC(WC), .WB(WB), .ECW(16)) bus ();
    array_2d_bist_if #(.WA(WA), .WC(WC), .WB(WB), .ECW(2))  bus_s ();

    array_2d_bist #(.WA(WA), .WC(WC), .WB(WB), .ECW(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    array_2d_bist #(.WA(WA), .WC(WC), .WB(WB), .ECW(2)) dut_s (
        .clk(clk),
        .rst(rst),
        .bus(bus_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural array with an optional stuck-at-0 on bit 0 of word [2][1].
    logic [WB-1:0] mem [WA][WC];
    bit fault_on = 0;

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_a][bus.mem_c] <= bus.mem_wdata;
        if (bus.mem_re)
            bus.mem_rdata <= mem[bus.mem_a][bus.mem_c] &
                             ((fault_on && bus.mem_a == 2'd2 && bus.mem_c == 2'd1) ? 8'hFE : 8'hFF);
    end

    // Second instance sees an array that always reads back zero.
    always @(posedge clk) bus_s.mem_rdata <= '0;

    // Reference model: the whole run as a list of expected bus cycles plus final results.
    typedef struct packed {
        logic       we;
        logic       re;
        logic [1:0] a;
        logic [1:0] c;
        logic [7:0] d;
    } op_t;

    op_t exp_ops[$];
    int  k = 0, run_len = 0;
    bit  run = 0;
    bit  r_pass, h_pass = 0;
    int  r_err, r_fa, r_fc;
    int  h_err = 0, h_fa = 0, h_fc = 0;
    bit  chk_en = 0;

    function automatic int pat_m(int a, int c);
        return (a % 16) * 16 + (c % 16);
    endfunction

    task automatic build_run(input int wa_i, input int wc_i, input bit flt);
        int wl, cl, e, rd, cnt;
        op_t op;
        wl  = (wa_i > WA) ? WA : wa_i;
        cl  = (wc_i > WC) ? WC : wc_i;
        cnt = 0;
        r_fa = 0;
        r_fc = 0;
        exp_ops.delete();
        for (int a = 0; a < WA; a++)
            for (int c = 0; c < WC; c++) begin
                op = '{1'b1, 1'b0, 2'(a), 2'(c), 8'hFF};
                exp_ops.push_back(op);
            end
        for (int a = 0; a < wl; a++)
            for (int c = 0; c < cl; c++) begin
                op = '{1'b1, 1'b0, 2'(a), 2'(c), 8'(pat_m(a, c))};
                exp_ops.push_back(op);
            end
        for (int a = 0; a < WA; a++)
            for (int c = 0; c < WC; c++) begin
                op = '{1'b0, 1'b1, 2'(a), 2'(c), 8'h00};
                exp_ops.push_back(op);
                e  = (a < wl && c < cl) ? pat_m(a, c) : 255;
                rd = (flt && a == 2 && c == 1) ? (e & 254) : e;
                if (rd != e) begin
                    cnt++;
                    if (cnt == 1) begin
                        r_fa = a;
                        r_fc = c;
                    end
                end
            end
        r_err   = cnt;
        r_pass  = (cnt == 0);
        run_len = exp_ops.size() + 2;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            run = 0; h_pass = 0; h_err = 0; h_fa = 0; h_fc = 0;
        end else if (run) begin
            k++;
            if (k == run_len) begin
                h_pass = r_pass; h_err = r_err; h_fa = r_fa; h_fc = r_fc;
            end else if (k > run_len) begin
                run = 0;
            end
        end else if (bus.start) begin
            build_run(int'(bus.wa), int'(bus.wc), fault_on);
            run = 1; k = 1;
            h_pass = 0; h_err = 0; h_fa = 0; h_fc = 0;
        end
    end

    // Cycle-by-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        op_t op;
        if (chk_en) begin
            chk("we_re_excl", bus.mem_we & bus.mem_re, 0);
            if (run && k <= exp_ops.size()) begin
                op = exp_ops[k-1];
                chk("bus_we", bus.mem_we, op.we);
                chk("bus_re", bus.mem_re, op.re);
                chk("bus_a", bus.mem_a, op.a);
                chk("bus_c", bus.mem_c, op.c);
                if (op.we) chk("bus_wdata", bus.mem_wdata, op.d);
                chk("busy_run", bus.busy, 1);
                chk("done_run", bus.done, 0);
                chk("pass_run", bus.pass, 0);
            end else begin
                chk("bus_idle", {bus.mem_we, bus.mem_re}, 0);
                chk("busy", bus.busy, run);
                chk("done", bus.done, (run && k == run_len) ? 1 : 0);
                if (!run || k == run_len) begin
                    chk("pass", bus.pass, h_pass);
                    chk("err_cnt", bus.err_cnt, h_err);
                    chk("fail_a", bus.fail_a, h_fa);
                    chk("fail_c", bus.fail_c, h_fc);
                end
            end
        end
    end

    task automatic run_one(input int wa_i, input int wc_i, input int mid, output int cyc);
        @(negedge clk);
        bus.start = 1'b1;
        bus.wa    = 3'(wa_i);
        bus.wc    = 2'(wc_i);
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 200) begin
            if (mid != 0 && cyc == mid) begin
                bus.start = 1'b1;
                bus.wa    = 3'($urandom_range(0, 7));
                bus.wc    = 2'($urandom_range(0, 3));
            end
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
        end
        if (bus.done !== 1'b1) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, bad, seen;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.wa      = '0;
        bus.wc      = '0;
        bus_s.start = 1'b0;
        bus_s.wa    = '0;
        bus_s.wc    = '0;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1;
        chk("rst_err_cnt", bus.err_cnt, 0);
        chk("rst_pass", bus.pass, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_we", bus.mem_we, 0);

        // Healthy array, partial region.
        run_one(2, 3, 0, cyc);
        chk("len_2x3", cyc, 32);
        chk("pass_2x3", bus.pass, 1);
        chk("err_2x3", bus.err_cnt, 0);
        chk("word_1_2", mem[1][2], 8'h12);
        chk("word_3_0", mem[3][0], 8'hFF);

        // Empty region: FILL skipped.
        run_one(0, 3, 0, cyc);
        chk("len_0x3", cyc, 26);
        chk("pass_0x3", bus.pass, 1);
        bad = 0;
        for (int a = 0; a < WA; a++)
            for (int c = 0; c < WC; c++)
                if (mem[a][c] != 8'hFF) bad++;
        chk("all_ff_0x3", bad, 0);

        // Stuck-at-0 inside and outside the region.
        fault_on = 1;
        run_one(4, 3, 0, cyc);
        chk("sa0_in_err", bus.err_cnt, 1);
        chk("sa0_in_fa", bus.fail_a, 2);
        chk("sa0_in_fc", bus.fail_c, 1);
        chk("sa0_in_pass", bus.pass, 0);
        run_one(2, 3, 0, cyc);
        chk("sa0_out_err", bus.err_cnt, 1);
        chk("sa0_out_fa", bus.fail_a, 2);
        chk("sa0_out_fc", bus.fail_c, 1);
        chk("sa0_out_pass", bus.pass, 0);
        fault_on = 0;

        // Reset in the 5th CLEAR cycle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.wa    = 3'd2;
        bus.wc    = 2'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_we", bus.mem_we, 0);
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_done", bus.done, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk("no_done_after_rst", seen, 0);
        run_one(2, 3, 0, cyc);
        chk("len_after_rst", cyc, 32);
        chk("pass_after_rst", bus.pass, 1);

        // Second start during FILL is ignored.
        run_one(2, 3, 15, cyc);
        chk("len_restart", cyc, 32);
        chk("pass_restart", bus.pass, 1);

        // Randomised runs.
        for (int i = 0; i < 12; i++) begin
            fault_on = 1'($urandom_range(0, 1));
            run_one($urandom_range(0, 7), $urandom_range(0, 3),
                    ($urandom_range(0, 1) != 0) ? $urandom_range(1, 25) : 0, cyc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        fault_on = 0;

        // Saturating 2-bit counter with an array that reads all zeros.
        @(negedge clk);
        bus_s.start = 1'b1;
        bus_s.wa    = 3'd0;
        bus_s.wc    = 2'd0;
        @(negedge clk);
        bus_s.start = 1'b0;
        cyc = 1;
        while (bus_s.done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("sat_len", cyc, 26);
        chk("sat_err", bus_s.err_cnt, 3);
        chk("sat_fa", bus_s.fail_a, 0);
        chk("sat_fc", bus_s.fail_c, 0);
        chk("sat_pass", bus_s.pass, 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/array_2d_bist.md
# array_2d_bist

Synthesizable built-in self-test controller for a 2D unpacked memory of WA × WC words, each WB bits wide. It sequences three phases: clear the whole array, fill a runtime-selected wa × wc sub-region with a coordinate pattern, then read back and check every word. It sits beside the array datapath and owns its single write/read port for the duration of a run. The result is reported as a pass flag, an error count and the coordinates of the first failing word.

## Interface
Parameters:
- WA, 4 — number of rows (first unpacked dimension); ≥1.
- WC, 4 — number of columns (second unpacked dimension); ≥1.
- WB, 8 — word width; must be even and ≥2.
- ECW, 16 — error counter width.

Ports:
- clk  in  1  — the single clock.
- rst  in  1  — reset, synchronous, active-high.
- start  in  1  — begin a run; sampled only in IDLE.
- wa  in  $clog2(WA+1)  — fill region rows; latched at start.
- wc  in  $clog2(WC+1)  — fill region columns; latched at start.
- mem_we  out  1  — write strobe.
- mem_re  out  1  — read strobe.
- mem_a  out  $clog2(WA) (min 1)  — row address.
- mem_c  out  $clog2(WC) (min 1)  — column address.
- mem_wdata  out  WB  — write data.
- mem_rdata  in  WB  — read data, valid exactly 1 cycle after mem_re.
- busy  out  1  — high from the cycle after start through DONE.
- done  out  1  — one-cycle pulse when the run completes.
- pass  out  1  — valid from done until the next start.
- err_cnt  out  ECW  — number of mismatches; saturates at all-ones.
- fail_a  out  width of mem_a  — row of the first mismatch; 0 if none.
- fail_c  out  width of mem_c  — column of the first mismatch; 0 if none.

## Operation
- Pattern function: pat(a,c) = {a[WB/2-1:0], c[WB/2-1:0]}. Indices are zero-extended when narrower than WB/2.
- Fill value: all ones ({WB{1'b1}}).
- Latched extents: wa_l = min(wa,WA) and wc_l = min(wc,WC).
- Scan order is row-major: c increments fastest, a increments on column wrap.
- States and transitions:
  - IDLE: on start, go to CLEAR. Clear err_cnt, fail_a, fail_c and pass.
  - CLEAR: write the fill value to all WA×WC words, one per cycle. After the last word, go to FILL, or to CHECK if wa_l==0 or wc_l==0.
  - FILL: write pat(a,c) for every a<wa_l, c<wc_l. After the last word, go to CHECK.
  - CHECK: read all WA×WC words, one per cycle.
    - Expected value: pat(a,c) inside the region, fill value outside.
    - The comparison uses a 1-cycle-delayed copy of the coordinates and expected word.
    - After the last read, go to DRAIN.
  - DRAIN: one cycle to compare the final read, then go to DONE.
  - DONE: assert done for one cycle, set pass = (err_cnt==0), go to IDLE.
- Mismatch handling: increment err_cnt, saturating. Capture fail_a/fail_c only on the first mismatch of a run.
- start while busy is ignored.
- mem_we and mem_re are never asserted in the same cycle.

## Timing
- Reset values: state IDLE; all outputs 0, including mem_we, mem_re, busy, done, pass and err_cnt.
- start seen in IDLE at edge n: first CLEAR write is issued in cycle n+1.
- Run length from start to done: WA·WC + wa_l·wc_l + WA·WC + 2 cycles (the +2 is DRAIN plus DONE).
- Memory outputs are registered: address, data and strobes change only on clk edges.
- Reset mid-run:
  - At the next edge, mem_we and mem_re drop to 0 and the state returns to IDLE.
  - pass, err_cnt and fail_* clear; no done pulse.
- Reset and start in the same cycle: reset wins.
- Wrap: c returns to 0 and a increments in the same cycle. The last word (WA-1, WC-1) triggers the phase transition with no extra idle cycle.

## Structure
- Package array_2d_bist_pkg holds:
  - the state enum (IDLE, CLEAR, FILL, CHECK, DRAIN, DONE);
  - the pat() function;
  - the FILL_VALUE constant.
- Sub-module array_2d_scan: a row-major 2D address counter.
  - Inputs: clear, enable, and row/column limits.
  - Outputs: a, c, and a last flag.
  - It is reused across all three phases, with limits (WA,WC) or (wa_l,wc_l).

## Test plan
All scenarios use WA=4, WC=3, WB=8 unless stated, with a behavioural memory model.
- wa=2, wc=3, correct memory:
  - done arrives 12+6+12+2 = 32 cycles after start.
  - pass=1, err_cnt=0.
  - Word [1][2]=0x12 and word [3][0]=0xFF.
- wa=0, wc=3: FILL skipped, done at 26 cycles, pass=1; all words 0xFF.
- Stuck-at-0 on bit 0 of word [2][1]:
  - wa=4, wc=3: pattern 0x21 reads 0x20, giving err_cnt=1, fail_a=2, fail_c=1, pass=0.
  - wa=2: fill 0xFF reads 0xFE, giving the same result.
- rst pulsed in the 5th CLEAR cycle:
  - Next cycle: mem_we=0, busy=0, no done.
  - A following start completes normally.
- start asserted again mid-FILL: ignored; run length and results unchanged.
- ECW=2, memory returning 0 for every read: err_cnt saturates at 3, fail_a=0, fail_c=0, pass=0.
